// File: rtl/irq_timer_pkg.sv
// rtl/irq_timer_pkg.sv - shared register map and field indices for the interrupt/timer block
package irq_timer_pkg;

    localparam int NUM_SRC     = 8;
    localparam int TIMER_SRC   = 0;
    localparam int TCTL_EN     = 0;
    localparam int TCTL_RELOAD = 1;

    typedef enum logic [2:0] {
        REG_PEND    = 3'd0,
        REG_MASK    = 3'd1,
        REG_EDGE    = 3'd2,
        REG_TCTL    = 3'd3,
        REG_TLOAD_L = 3'd4,
        REG_TLOAD_H = 3'd5,
        REG_TSNAP_L = 3'd6,
        REG_TSNAP_H = 3'd7
    } reg_off_e;

endpackage

// File: rtl/irq_timer.sv
// rtl/irq_timer.sv - prescaled 16-bit down counter with reload/one-shot and snapshot
module irq_timer
    import irq_timer_pkg::*;
#(
    parameter int DIV = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tctl_wr,
    input  logic        i_tload_l_wr,
    input  logic        i_tload_h_wr,
    input  logic        i_snap_wr,
    input  logic [7:0]  i_wdata,
    output logic        o_en,
    output logic        o_reload,
    output logic [15:0] o_tload,
    output logic [15:0] o_snap,
    output logic        o_term
);

    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic          r_en;
    logic          r_reload;
    logic [15:0]   r_tload;
    logic [15:0]   r_count;
    logic [15:0]   r_snap;
    logic [PW-1:0] r_pre;

    logic w_wrap;
    logic w_term;
    logic w_start;

    assign w_wrap  = r_en && (r_pre == PRE_LAST);
    assign w_term  = w_wrap && (r_count == 16'd1);
    assign w_start = i_tctl_wr && !r_en && i_wdata[TCTL_EN];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en     <= 1'b0;
            r_reload <= 1'b0;
            r_tload  <= 16'd0;
            r_count  <= 16'd0;
            r_snap   <= 16'd0;
            r_pre    <= '0;
        end else begin
            if (i_tload_l_wr) r_tload[7:0]  <= i_wdata;
            if (i_tload_h_wr) r_tload[15:8] <= i_wdata;
            if (i_snap_wr)    r_snap        <= r_count;

            // A count of 0 simply wraps to FFFF, giving TLOAD=0 a 65536-tick period
            if (w_start) begin
                r_count <= r_tload;
                r_pre   <= '0;
            end else if (r_en) begin
                if (w_wrap) begin
                    r_pre <= '0;
                    if (w_term) r_count <= r_reload ? r_tload : 16'd0;
                    else        r_count <= r_count - 16'd1;
                end else begin
                    r_pre <= r_pre + PW'(1);
                end
            end

            // An explicit TCTL write overrides the one-shot self-disable
            if (i_tctl_wr) begin
                r_en     <= i_wdata[TCTL_EN];
                r_reload <= i_wdata[TCTL_RELOAD];
            end else if (w_term && !r_reload) begin
                r_en <= 1'b0;
            end
        end
    end

    assign o_en     = r_en;
    assign o_reload = r_reload;
    assign o_tload  = r_tload;
    assign o_snap   = r_snap;
    assign o_term   = w_term;

endmodule

// File: rtl/irq_timer_ctrl.sv
// rtl/irq_timer_ctrl.sv - byte-bus interrupt controller: decode, sync, edge detect, PEND/MASK/EDGE, intr
module irq_timer_ctrl
    import irq_timer_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'hFF00,
    parameter int          DIV         = 256,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_read,
    input  logic [15:0] i_address,
    input  logic [7:0]  i_wdata,
    output logic [7:0]  o_rdata,
    output logic        o_sel,
    input  logic [7:1]  i_irq_in,
    output logic        o_intr
);

    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_edge;
    logic [7:1]         r_sync_prev;
    logic               r_intr;

    logic [7:1]         w_sync;
    logic [7:1]         w_ext_set;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_w1c;
    logic               w_sel;
    logic               w_wr;
    reg_off_e           w_off;
    logic               w_en;
    logic               w_reload;
    logic               w_term;
    logic [15:0]        w_tload;
    logic [15:0]        w_snap;

    assign w_sel = (i_address[15:3] == BASE[15:3]);
    assign w_wr  = !i_read && w_sel;
    assign w_off = reg_off_e'(i_address[2:0]);

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_sync = i_irq_in;
        end else begin : g_sync
            logic [7:1] r_sync [SYNC_STAGES];
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
                end else begin
                    r_sync[0] <= i_irq_in;
                    for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
                end
            end
            assign w_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_ext_set = (r_edge[7:1] & w_sync & ~r_sync_prev) | (~r_edge[7:1] & w_sync);

    always_comb begin
        w_set            = {w_ext_set, 1'b0};
        w_set[TIMER_SRC] = w_term;
    end

    assign w_w1c = (w_wr && w_off == REG_PEND) ? i_wdata : 8'h00;

    irq_timer #(
        .DIV(DIV)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_tctl_wr    (w_wr && w_off == REG_TCTL),
        .i_tload_l_wr (w_wr && w_off == REG_TLOAD_L),
        .i_tload_h_wr (w_wr && w_off == REG_TLOAD_H),
        .i_snap_wr    (w_wr && w_off == REG_TSNAP_L),
        .i_wdata      (i_wdata),
        .o_en         (w_en),
        .o_reload     (w_reload),
        .o_tload      (w_tload),
        .o_snap       (w_snap),
        .o_term       (w_term)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend      <= '0;
            r_mask      <= '0;
            r_edge      <= '0;
            r_sync_prev <= '0;
            r_intr      <= 1'b0;
        end else begin
            // Set is OR-ed after the clear so a coincident source event survives W1C
            r_pend      <= (r_pend & ~w_w1c) | w_set;
            r_sync_prev <= w_sync;
            r_intr      <= |(r_pend & r_mask);
            if (w_wr && w_off == REG_MASK) r_mask <= i_wdata;
            if (w_wr && w_off == REG_EDGE) r_edge <= i_wdata;
        end
    end

    always_comb begin
        o_rdata = 8'h00;
        if (w_sel) begin
            case (w_off)
                REG_PEND:    o_rdata = r_pend;
                REG_MASK:    o_rdata = r_mask;
                REG_EDGE:    o_rdata = r_edge;
                REG_TCTL:    o_rdata = {6'b0, w_reload, w_en};
                REG_TLOAD_L: o_rdata = w_tload[7:0];
                REG_TLOAD_H: o_rdata = w_tload[15:8];
                REG_TSNAP_L: o_rdata = w_snap[7:0];
                REG_TSNAP_H: o_rdata = w_snap[15:8];
                default:     o_rdata = 8'h00;
            endcase
        end
    end

    assign o_sel  = w_sel;
    assign o_intr = r_intr;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// tb/tb_irq_timer_ctrl.sv - randomized and directed bench for irq_timer_ctrl against a behavioural model
module tb_irq_timer_ctrl;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam int          DIV  = 4;
    localparam int          SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        sel;
    logic [7:1]  irq;
    logic        intr;

    always #5 clk = ~clk;

    irq_timer_ctrl #(
        .BASE(BASE), .DIV(DIV), .SYNC_STAGES(SYNC)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_read(rd), .i_address(addr), .i_wdata(wdata),
        .o_rdata(rdata), .o_sel(sel), .i_irq_in(irq), .o_intr(intr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:1] pin_v;
    logic [7:0] g_rdata;
    logic       g_sel;
    logic       g_intr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural model state
    logic [7:0]  m_pend, m_mask, m_edge;
    logic        m_en, m_rel, m_intr;
    logic [15:0] m_tload, m_count, m_snap;
    int          m_pre;
    logic [7:1]  m_prev;
    logic [7:1]  m_pipe [$];

    function automatic logic in_win(input logic [15:0] a);
        return (32'(a) >= 32'(BASE)) && (32'(a) <= 32'(BASE) + 7);
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] a);
        if (!in_win(a)) return 8'h00;
        case (int'(a - BASE))
            0:       return m_pend;
            1:       return m_mask;
            2:       return m_edge;
            3:       return {6'b0, m_rel, m_en};
            4:       return m_tload[7:0];
            5:       return m_tload[15:8];
            6:       return m_snap[7:0];
            default: return m_snap[15:8];
        endcase
    endfunction

    task automatic m_reset();
        m_pend = 0; m_mask = 0; m_edge = 0; m_en = 0; m_rel = 0; m_intr = 0;
        m_tload = 0; m_count = 0; m_snap = 0; m_pre = 0; m_prev = 0;
        m_pipe = {};
        repeat (SYNC) m_pipe.push_back(7'h0);
    endtask

    task automatic m_step(input logic r, input logic rdn, input logic [15:0] a,
                          input logic [7:0] d, input logic [7:1] pin);
        logic [7:1]  s, ext;
        logic [7:0]  w1c;
        logic        term, old_en, old_rel;
        logic [15:0] old_count, old_tload;
        if (r) begin
            m_reset();
            return;
        end
        if (SYNC == 0) s = pin;
        else           s = m_pipe[$];
        for (int i = 1; i < 8; i++) ext[i] = m_edge[i] ? (s[i] && !m_prev[i]) : s[i];
        m_intr    = |(m_pend & m_mask);
        old_en    = m_en;
        old_rel   = m_rel;
        old_count = m_count;
        old_tload = m_tload;
        term      = 1'b0;
        w1c       = 8'h00;
        if (old_en) begin
            if (m_pre == DIV - 1) begin
                m_pre = 0;
                if (m_count == 16'd1) begin
                    term = 1'b1;
                    if (old_rel) m_count = old_tload;
                    else begin m_count = 16'd0; m_en = 1'b0; end
                end else begin
                    m_count = m_count - 16'd1;
                end
            end else begin
                m_pre++;
            end
        end
        if (!rdn && in_win(a)) begin
            case (int'(a - BASE))
                0: w1c = d;
                1: m_mask = d;
                2: m_edge = d;
                3: begin
                    if (!old_en && d[0]) begin m_count = old_tload; m_pre = 0; end
                    m_en  = d[0];
                    m_rel = d[1];
                end
                4: m_tload[7:0]  = d;
                5: m_tload[15:8] = d;
                6: m_snap = old_count;
                default: ;
            endcase
        end
        m_pend = (m_pend & ~w1c) | {ext, term};
        m_prev = s;
        if (SYNC > 0) begin
            m_pipe.push_front(pin);
            void'(m_pipe.pop_back());
        end
    endtask

    task automatic cycle(input logic r, input logic rdn, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        rst = r; rd = rdn; addr = a; wdata = d; irq = pin_v;
        #1;
        g_rdata = rdata; g_sel = sel; g_intr = intr;
        chk("sel", 32'(sel), 32'(in_win(a)));
        chk("rdata", 32'(rdata), 32'(m_read(a)));
        chk("intr", 32'(intr), 32'(m_intr));
        @(posedge clk);
        m_step(r, rdn, a, d, pin_v);
        cyc++;
    endtask

    task automatic wr(input int off, input logic [7:0] d);
        cycle(1'b0, 1'b0, BASE + 16'(off), d);
    endtask

    task automatic rdr(input int off);
        cycle(1'b0, 1'b1, BASE + 16'(off), 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b1, 16'h0000, 8'h00);
    endtask

    task automatic wait_tmr(input string tag, input int max, output int t);
        logic found;
        found = 1'b0;
        t = -1;
        for (int i = 0; i < max && !found; i++) begin
            rdr(0);
            if (g_rdata[0]) begin found = 1'b1; t = cyc; end
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int t1, t2, r;
        logic [15:0] a;
        rst = 1'b1; rd = 1'b1; addr = 16'h0; wdata = 8'h0; irq = 7'h0; pin_v = 7'h0;
        m_reset();
        repeat (3) @(posedge clk);

        // Reset state and window boundaries
        for (int o = 0; o < 8; o++) begin
            rdr(o);
            chk("rst_reg", 32'(g_rdata), 32'd0);
        end
        chk("rst_intr", 32'(g_intr), 32'd0);
        cycle(1'b0, 1'b1, BASE - 16'd1, 8'h00);
        chk("below_sel", 32'(g_sel), 32'd0);
        chk("below_rdata", 32'(g_rdata), 32'd0);
        cycle(1'b0, 1'b1, BASE + 16'd8, 8'h00);
        chk("above_sel", 32'(g_sel), 32'd0);
        chk("above_rdata", 32'(g_rdata), 32'd0);

        // Edge source 2 through mask
        wr(1, 8'h04);
        wr(2, 8'h04);
        pin_v[2] = 1'b1; idle(1); pin_v[2] = 1'b0;
        idle(2);
        rdr(0);
        chk("edge_pend", 32'(g_rdata), 32'h04);
        chk("edge_intr_early", 32'(g_intr), 32'd0);
        idle(1);
        chk("edge_intr", 32'(g_intr), 32'd1);
        wr(0, 8'h04);
        idle(2);
        chk("w1c_intr", 32'(g_intr), 32'd0);

        // Level source 3
        pin_v[3] = 1'b1; idle(4);
        wr(0, 8'h08); rdr(0);
        chk("level_reset", 32'(g_rdata & 8'h08), 32'h08);
        pin_v[3] = 1'b0; idle(4);
        wr(0, 8'h08); rdr(0);
        chk("level_clear", 32'(g_rdata & 8'h08), 32'h00);

        // W1C coincident with an edge set
        pin_v[2] = 1'b1; idle(1); pin_v[2] = 1'b0; idle(4);
        pin_v[2] = 1'b1; idle(2);
        wr(0, 8'h04);
        pin_v[2] = 1'b0;
        rdr(0);
        chk("set_wins", 32'(g_rdata & 8'h04), 32'h04);
        wr(0, 8'hFF); wr(1, 8'h01);

        // Periodic timer then one-shot
        wr(4, 8'h03); wr(5, 8'h00); wr(3, 8'h03);
        wait_tmr("tmr_first_to", 40, t1);
        wr(0, 8'h01);
        wait_tmr("tmr_second_to", 40, t2);
        chk("tmr_period", 32'(t2 - t1), 32'd12);
        wr(0, 8'h01);
        wr(3, 8'h01);
        wait_tmr("tmr_oneshot_to", 40, t1);
        rdr(3);
        chk("oneshot_en", 32'(g_rdata), 32'h00);
        wr(0, 8'h01);
        idle(30);
        rdr(0);
        chk("oneshot_quiet", 32'(g_rdata & 8'h01), 32'h00);
        wr(6, 8'h00); rdr(6);
        chk("oneshot_cnt_l", 32'(g_rdata), 32'h00);
        rdr(7);
        chk("oneshot_cnt_h", 32'(g_rdata), 32'h00);

        // Snapshot while running
        wr(4, 8'h34); wr(5, 8'h12); wr(3, 8'h01);
        idle(10);
        wr(6, 8'hA5);
        rdr(6); chk("snap_l", 32'(g_rdata), 32'h32);
        rdr(7); chk("snap_h", 32'(g_rdata), 32'h12);
        idle(20);
        rdr(6); chk("snap_frozen", 32'(g_rdata), 32'h32);
        wr(6, 8'h00); rdr(6); rdr(7);

        // TLOAD=0 wraps to FFFF without an event
        wr(3, 8'h00); wr(4, 8'h00); wr(5, 8'h00); wr(3, 8'h01);
        idle(5);
        wr(6, 8'h00);
        rdr(6); chk("wrap_l", 32'(g_rdata), 32'hFF);
        rdr(7); chk("wrap_h", 32'(g_rdata), 32'hFF);
        rdr(0); chk("wrap_noevt", 32'(g_rdata & 8'h01), 32'h00);
        wr(3, 8'h00);

        // Randomized traffic checked every cycle against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) pin_v = 7'($urandom);
            r = int'($urandom_range(0, 99));
            a = BASE - 16'd4 + 16'($urandom_range(0, 15));
            if (r < 1)       cycle(1'b1, 1'b1, a, 8'h00);
            else if (r < 50) cycle(1'b0, 1'b1, a, 8'h00);
            else if (r < 80) wr(int'($urandom_range(0, 2)), 8'($urandom));
            else if (r < 85) wr(3, 8'($urandom_range(0, 3)));
            else if (r < 90) wr(4, 8'($urandom_range(0, 7)));
            else if (r < 92) wr(5, 8'h00);
            else if (r < 95) wr(6, 8'h00);
            else             cycle(1'b0, 1'b0, 16'h1000 + 16'($urandom_range(0, 7)), 8'($urandom));
        end

        // Reset mid-operation
        wr(1, 8'hFF); pin_v = 7'h7F; idle(5);
        cycle(1'b1, 1'b1, 16'h0000, 8'h00);
        pin_v = 7'h00;
        idle(1);
        chk("rst_mid_intr", 32'(g_intr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_timer_ctrl.md
# irq_timer_ctrl

Memory-mapped interrupt controller with an integrated 16-bit tick timer, sitting upstream of the CPU's `intr` input and on its byte-wide bus. It collects seven external request lines plus the timer, latches them into pending bits, and applies a mask. It drives a single level `intr` to the CPU. The CPU's register window is 8 bytes with no read side effects, because instruction fetches may address it.

## Interface
- `BASE`, 16'hFF00: byte address of register 0; window is `BASE`..`BASE`+7; must be 8-aligned.
- `DIV`, 256: prescaler ratio; the timer decrements once per `DIV` enabled clocks; legal range 1..65536.
- `SYNC_STAGES`, 2: synchronizer flops on `irq_in`; 0 means inputs are already synchronous.
- `clk`  in  1: single clock; block is posedge-clocked and samples CPU bus outputs launched on the preceding negedge.
- `rst`  in  1: synchronous, active-high reset.
- `read`  in  1: CPU bus direction; 0 = write strobe.
- `address`  in  16: CPU bus address.
- `wdata`  in  8: CPU write data (CPU `dout`).
- `rdata`  out  8: read data, combinational from `address`; 0 when not selected.
- `sel`  out  1: combinational; high when `address` is in the window; top level uses it to mux `rdata` onto CPU `din`.
- `irq_in`  in  7: external requests, sources 7..1.
- `intr`  out  1: registered; equals |(PEND & MASK); reset 0.

## Operation
- Write takes effect at the posedge where `read`=0 and `sel`=1. Reads are pure muxes with no state change.
- Register map by offset:
  - 0 PEND: R, write-1-to-clear; bit 0 = timer.
  - 1 MASK: RW.
  - 2 EDGE: RW; 1 = rising-edge, 0 = level; bit 0 ignored, timer is always a pulse.
  - 3 TCTL: bit0 EN, bit1 RELOAD; other bits read 0.
  - 4 TLOAD_L and 5 TLOAD_H: RW.
  - 6 TSNAP_L: write any value to capture the live count into the snapshot; read returns snapshot[7:0].
  - 7 TSNAP_H: read returns snapshot[15:8]; writes ignored.
- Reset values are all 0. This includes count, prescaler, edge history and synchronizers.
- Source set rules:
  - Edge source: pending set on a synchronized 0→1 transition.
  - Level source: pending set every cycle the synchronized input is 1.
- A set event and a W1C of the same bit in the same cycle: set wins.
- Timer:
  - A TCTL write with EN 0→1 loads count←TLOAD and prescaler←0.
  - While EN=1, the prescaler counts 0..`DIV`-1. On wrap, count decrements.
  - A decrement from 1 to 0 is a terminal event: it sets PEND[0].
    - RELOAD=1: count←TLOAD in the same cycle.
    - RELOAD=0: EN←0 and count stays 0.
  - TLOAD=0 behaves as a period of 65536 ticks (0→FFFF wrap, no event).
- A write of EN=1 while already enabled does not reload. Writing EN=0 freezes count and prescaler.
- TLOAD writes do not disturb a running count; they affect only the next load.

## Timing
- Write to MASK, or W1C of PEND, at posedge N: `intr` reflects the new state at posedge N+1.
- External edge at the sync output at posedge N: PEND bit set at N+1, `intr` high at N+2. Add `SYNC_STAGES` cycles from the pin.
- Timer terminal event at posedge N: PEND[0] set at N, `intr` at N+1.
- `rst` mid-operation clears everything at that posedge; `intr` is 0 the following cycle.
- The CPU samples `intr` only at even PC outside supervisor mode. `intr` is held until software clears PEND or MASK; no acknowledge handshake.

## Structure
- Shared package `irq_timer_pkg`: register offsets `REG_PEND`..`REG_TSNAP_H`, TCTL bit indices `TCTL_EN` and `TCTL_RELOAD`, source count 8, timer source index 0.
- Sub-module `irq_timer`: prescaler, 16-bit down counter, reload/one-shot logic, terminal pulse output, snapshot register.
- Top level holds the address decode, synchronizers, edge detect, PEND/MASK/EDGE registers and the `intr` flop.

## Test plan
- Reset, then read offsets 0..7 → all 0, `intr`=0; address `BASE`-1 and `BASE`+8 → `sel`=0, `rdata`=0.
- MASK=8'h04, pulse `irq_in`[2] (edge mode) → PEND=8'h04, `intr`=1 at sync+2 cycles; write PEND=8'h04 → `intr`=0 next cycle.
- Level mode: hold `irq_in`[3] high, W1C bit 3 → PEND[3] reads 1 again next cycle; drop input then W1C → stays 0; W1C coincident with edge → bit remains set.
- `DIV`=4, TLOAD=3, TCTL=8'h03 → PEND[0] set every 12 clocks; clear RELOAD → one more event, then EN reads 0 and count holds 0.
- Timer running with TLOAD=16'h1234: write TSNAP_L, read 6/7 → snapshot value frozen while the live count continues; TLOAD=0 → first event after 65536·`DIV` clocks.
